// File: rtl/permute_engine.sv
// Streams LANES lanes from a source memory to a destination memory, one lane per
// cycle, optionally applying the Keccak rho lane rotation and/or the pi lane permutation.
module permute_engine #(
    parameter int LANE_W = 64,
    parameter int LANES  = 25,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [LANE_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LANE_W-1:0] wr_data,
    output logic              ready,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Handshake: start is a level sampled only while ready=1 (IDLE); a sampled start
    // commits a full pass. rd_data must be valid the cycle after rd_en; every write
    // strobe wr_en is a single-cycle, always-accepted transfer; done pulses once.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LANES - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [1:0]        r_mode;
    logic              r_rd_en;
    logic              r_ready;
    logic              r_done;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_idx;
    logic [LANE_W-1:0] w_xform;

    function automatic int rho_off(input int i);
        case (i)
            0: return 0;    1: return 1;    2: return 62;   3: return 28;   4: return 27;
            5: return 36;   6: return 44;   7: return 6;    8: return 55;   9: return 20;
            10: return 3;   11: return 10;  12: return 43;  13: return 25;  14: return 39;
            15: return 41;  16: return 45;  17: return 15;  18: return 21;  19: return 8;
            20: return 18;  21: return 2;   22: return 61;  23: return 56;  24: return 14;
            default: return 0;
        endcase
    endfunction

    function automatic int pi_dest(input int i);
        int x;
        int y;
        x = i % 5;
        y = i / 5;
        return y + 5 * ((2 * x + 3 * y) % 5);
    endfunction

    function automatic logic [ADDR_W-1:0] dest(input logic [ADDR_W-1:0] idx, input logic [1:0] m);
        if (m[1] && (LANES == 25))
            return ADDR_W'(pi_dest(int'(idx)));
        return idx;
    endfunction

    // Rotate left via a doubled vector so any amount below LANE_W wraps without loss.
    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int amt);
        logic [2*LANE_W-1:0] w;
        w = {v, v} << amt;
        return w[2*LANE_W-1:LANE_W];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= 2'b00;
            r_rd_en <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_mode  <= mode;
                        r_cnt   <= '0;
                        r_rd_en <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_cnt == LAST_IDX) begin
                        r_state <= S_DRAIN;
                        r_rd_en <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rd_en <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Write stage trails the read by one cycle, matching the source memory latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_idx     <= '0;
        end else begin
            r_wr_en   <= r_rd_en;
            r_wr_addr <= r_rd_en ? dest(r_cnt, r_mode) : '0;
            r_idx     <= r_rd_en ? r_cnt : '0;
        end
    end

    always_comb begin
        w_xform = rd_data;
        if (r_mode[0])
            w_xform = rotl(rd_data, rho_off(int'(r_idx)) % LANE_W);
    end

    assign rd_en     = r_rd_en;
    assign rd_addr   = r_cnt;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_en ? w_xform : '0;
    assign ready     = r_ready;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_permute_engine.sv
// Directed bench for permute_engine: a 64-bit default instance and an 8-bit lane
// instance share clock, reset, start and mode, each with its own source memory.
module tb_permute_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;

    logic        rd_en, wr_en, ready, done;
    logic [4:0]  rd_addr, wr_addr;
    logic [63:0] rd_data, wr_data;
    logic [1:0]  dbg_state;

    logic        rd_en8, wr_en8, ready8, done8;
    logic [4:0]  rd_addr8, wr_addr8;
    logic [7:0]  rd_data8, wr_data8;
    logic [1:0]  dbg_state8;

    logic [63:0] src64 [0:31];
    logic [7:0]  src8  [0:31];
    logic [63:0] wdat  [0:31];
    logic [7:0]  wdat8 [0:31];
    int          wcnt  [0:31];

    int n_checks, n_fail;
    int n_rd, n_wr, n_done, seq_bad;
    int first_rd, last_rd, first_wr, last_wr, done_cyc, ready_cyc;

    int pi_tab [0:24] = '{0, 10, 20, 5, 15, 16, 1, 11, 21, 6, 7, 17, 2, 12, 22,
                          23, 8, 18, 3, 13, 14, 24, 9, 19, 4};

    permute_engine u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready), .done(done), .dbg_state(dbg_state)
    );

    permute_engine #(.LANE_W(8), .LANES(25), .ADDR_W(5)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_data8),
        .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .ready(ready8), .done(done8), .dbg_state(dbg_state8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous source memories; garbage is returned when no read was issued
    always @(posedge clk) begin
        if (rd_en) rd_data <= src64[rd_addr];
        else       rd_data <= {$urandom, $urandom};
        if (rd_en8) rd_data8 <= src8[rd_addr8];
        else        rd_data8 <= 8'($urandom_range(0, 255));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 32; i++) begin
            src64[i] = '0;
            src8[i]  = '0;
        end
    endtask

    // one pass from a start pulse (or held start); results land in module-level counters
    task automatic run_pass(input logic [1:0] m, input bit hold);
        for (int i = 0; i < 32; i++) begin
            wcnt[i] = 0; wdat[i] = '0; wdat8[i] = '0;
        end
        n_rd = 0; n_wr = 0; n_done = 0; seq_bad = 0;
        first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
        done_cyc = -1; ready_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        mode = ~m;
        for (int k = 1; k <= 40 && ready_cyc < 0; k++) begin
            @(negedge clk);
            if (rd_en) begin
                if (int'(rd_addr) != n_rd) seq_bad++;
                n_rd++;
                if (first_rd < 0) first_rd = k;
                last_rd = k;
            end
            if (wr_en) begin
                n_wr++;
                wcnt[wr_addr]++;
                wdat[wr_addr] = wr_data;
                if (first_wr < 0) first_wr = k;
                last_wr = k;
            end
            if (wr_en8) wdat8[wr_addr8] = wr_data8;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (ready && ready_cyc < 0) ready_cyc = k;
        end
    endtask

    task automatic check_pass(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 25; i++) if (wcnt[i] != 1) bad++;
        for (int i = 25; i < 32; i++) if (wcnt[i] != 0) bad++;
        check({tag, "_n_rd"}, 64'(n_rd), 64'd25);
        check({tag, "_n_wr"}, 64'(n_wr), 64'd25);
        check({tag, "_rd_seq"}, 64'(seq_bad), 64'd0);
        check({tag, "_first_rd"}, 64'(first_rd), 64'd1);
        check({tag, "_last_rd"}, 64'(last_rd), 64'd25);
        check({tag, "_first_wr"}, 64'(first_wr), 64'd2);
        check({tag, "_last_wr"}, 64'(last_wr), 64'd26);
        check({tag, "_done_cyc"}, 64'(done_cyc), 64'd27);
        check({tag, "_n_done"}, 64'(n_done), 64'd1);
        check({tag, "_ready_cyc"}, 64'(ready_cyc), 64'd28);
        check({tag, "_wr_once"}, 64'(bad), 64'd0);
    endtask

    task automatic wait_ready(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check({tag, "_ready_timeout"}, 64'(seen), 64'd1);
    endtask

    initial begin
        int act;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        clear_src();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // rho only, both lane widths
        clear_src();
        src64[1] = 64'h1;
        src64[2] = 64'h1;
        src64[3] = 64'h8000_0000_0000_0001;
        src8[1]  = 8'h81;
        src8[2]  = 8'h01;
        src8[24] = 8'h01;
        run_pass(2'b01, 1'b0);
        check_pass("rho");
        check("rho_lane0", wdat[0], 64'h0);
        check("rho_lane1", wdat[1], 64'h2);
        check("rho_lane2", wdat[2], 64'h4000_0000_0000_0000);
        check("rho_lane3_wrap", wdat[3], 64'h0000_0000_1800_0000);
        check("rho8_lane1", 64'(wdat8[1]), 64'h03);
        check("rho8_lane2", 64'(wdat8[2]), 64'h40);
        check("rho8_lane24", 64'(wdat8[24]), 64'h40);

        // pi only: lane i holds i, so the destination content names its source
        clear_src();
        for (int i = 0; i < 25; i++) src64[i] = 64'(i);
        run_pass(2'b10, 1'b0);
        check_pass("pi");
        for (int i = 0; i < 25; i++)
            check($sformatf("pi_src%0d", i), wdat[pi_tab[i]], 64'(i));

        // rho then pi
        clear_src();
        src64[1] = 64'h1;
        src64[2] = 64'h1;
        run_pass(2'b11, 1'b0);
        check_pass("rhopi");
        check("rhopi_addr10", wdat[10], 64'h2);
        check("rhopi_addr20", wdat[20], 64'h4000_0000_0000_0000);
        check("rhopi_addr1", wdat[1], 64'h0);

        // identity with random lanes
        for (int i = 0; i < 25; i++) src64[i] = {$urandom, $urandom};
        run_pass(2'b00, 1'b0);
        check_pass("ident");
        for (int i = 0; i < 25; i += 3)
            check($sformatf("ident_lane%0d", i), wdat[i], src64[i]);

        // start held high across the whole pass
        run_pass(2'b00, 1'b1);
        check_pass("hold");
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("hold_restart_rd_en", 64'(rd_en), 64'd1);
        check("hold_restart_addr", 64'(rd_addr), 64'd0);
        wait_ready("hold");

        // reset in cycle 10 of a pass
        @(negedge clk);
        start = 1'b1;
        mode  = 2'b01;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rd_en", 64'(rd_en), 64'd0);
        check("midrst_wr_en", 64'(wr_en), 64'd0);
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_wr_data", wr_data, 64'd0);
        check("midrst_rd_addr", 64'(rd_addr), 64'd0);
        act = 0;
        repeat (3) begin
            @(negedge clk);
            if (rd_en || wr_en || done) act++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rd_en || wr_en || done) act++;
        end
        check("midrst_no_activity", 64'(act), 64'd0);
        for (int i = 0; i < 25; i++) src64[i] = {$urandom, $urandom};
        run_pass(2'b00, 1'b0);
        check_pass("after_rst");
        check("after_rst_lane0", wdat[0], src64[0]);
        check("after_rst_lane24", wdat[24], src64[24]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
